// File: rtl/nat1_ram_stream_loader.sv
`default_nettype none
// =============================================================================
// Module      : nat1_ram_stream_loader
// Description : Loads one SOP/EOP-framed byte packet per start into a 1-cycle
//               RAM write port. Optional macro: NAT1_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module nat1_ram_stream_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sop,
  input  logic              s_eop,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count
`ifdef NAT1_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    LOAD    = 3'd2,
    DRAIN   = 3'd3,
    DONE_ST = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   c_last_idx = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   c_one      = (ADDR_W+1)'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_take;
  logic                w_arm;
  logic                w_ovf;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W:0]     r_count;
  logic                r_done;
  logic                r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    busy        = 1'b0;
    w_take      = 1'b0;
    w_arm       = 1'b0;
    w_ovf       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ARMED;
          w_arm       = 1'b1;
        end
      end
      ARMED, LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        // In ARMED only an SOP beat opens the packet; in LOAD every beat is data.
        if (s_valid && (s_sop || (r_state == LOAD))) begin
          w_take      = 1'b1;
          w_state_nxt = LOAD;
          if (s_eop) begin
            w_state_nxt = DONE_ST;
          end else if (r_count == c_last_idx) begin
            w_ovf       = 1'b1;
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_eop) begin
          w_state_nxt = DONE_ST;
        end
      end
      DONE_ST: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Abort overrides everything, including a start or a beat in the same cycle.
    if (abort) begin
      w_state_nxt = IDLE;
      w_take      = 1'b0;
      w_arm       = 1'b0;
      w_ovf       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_addr  <= c_base;
      r_data  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wr <= w_take;
      if (w_take) begin
        r_addr  <= c_base + r_count[ADDR_W-1:0];
        r_data  <= s_data;
        r_count <= r_count + c_one;
      end
      if (w_arm) begin
        r_count <= '0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
      end
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end
      // Registered off DONE_ST so done never coincides with the final write.
      if (r_state == DONE_ST) begin
        r_done <= 1'b1;
      end
    end
  end

`ifdef NAT1_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_arm) begin
      r_checksum <= '0;
    end else if (w_take) begin
      r_checksum <= r_checksum + s_data;
    end
  end

  assign checksum = r_checksum;
`endif

  assign m_chipselect = r_wr;
  assign m_write      = r_wr;
  assign m_address    = r_addr;
  assign m_writedata  = r_data;
  assign done         = r_done;
  assign overflow     = r_ovf;
  assign byte_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_nat1_ram_stream_loader.sv
`default_nettype none
// =============================================================================
// Module      : tb_nat1_ram_stream_loader
// Description : Directed self-checking bench for nat1_ram_stream_loader.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_nat1_ram_stream_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_sop;
  logic              s_eop;
  logic              m_chipselect;
  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   byte_count;
`ifdef NAT1_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // RAM model with 1-cycle read latency plus a log of every write issued
  logic [DATA_W-1:0] mem [0:1023];
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_q;
  int wa[$];
  int wd[$];
  int wc[$];

  nat1_ram_stream_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sop        (s_sop),
    .s_eop        (s_eop),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
`ifdef NAT1_LOADER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_chipselect && m_write) begin
      mem[m_address] <= m_writedata;
      wa.push_back(int'(m_address));
      wd.push_back(int'(m_writedata));
      wc.push_back(cyc);
    end
    rd_q <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  // Called at a negedge; returns at the negedge after the beat is taken.
  task automatic send(input logic [7:0] d, input logic sop, input logic eop);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sop   = sop;
    s_eop   = eop;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [7:0] exp_b;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
    rd_addr = '0;
    idle(3);
    check("rst_m_write", 32'(m_write), 0);
    check("rst_m_cs", 32'(m_chipselect), 0);
    check("rst_m_addr", 32'(m_address), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_count", 32'(byte_count), 0);
    reset = 1'b0;
    idle(1);

    // T1: reset while the third write is in flight
    clear_log();
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    check("t1_inflight_addr", 32'(m_address), 2);
    s_valid = 1'b1;
    s_data  = 8'h04;
    reset   = 1'b1;
    #1;
    check("t1_rst_m_write", 32'(m_write), 0);
    check("t1_rst_busy", 32'(busy), 0);
    check("t1_rst_count", 32'(byte_count), 0);
    check("t1_rst_addr", 32'(m_address), 0);
    idle(2);
    reset = 1'b0;
    idle(3);
    check("t1_writes", 32'(wa.size()), 2);
    check("t1_idle_ready", 32'(s_ready), 0);
    check("t1_idle_busy", 32'(busy), 0);
    s_valid = 1'b0;

    // T2: 4-beat back-to-back packet
    clear_log();
    pulse_start();
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b1);
    check("t2_last_write", 32'(m_write), 1);
    check("t2_last_addr", 32'(m_address), 3);
    check("t2_last_data", 32'(m_writedata), 32'h44);
    check("t2_done_not_early", 32'(done), 0);
    idle(1);
    check("t2_done", 32'(done), 1);
    check("t2_busy", 32'(busy), 0);
    check("t2_count", 32'(byte_count), 4);
    check("t2_ovf", 32'(overflow), 0);
    check("t2_writes", 32'(wa.size()), 4);
    check("t2_a0", 32'(wa[0]), 0);
    check("t2_d0", 32'(wd[0]), 32'h11);
    check("t2_a3", 32'(wa[3]), 3);
    check("t2_d3", 32'(wd[3]), 32'h44);
    check("t2_b2b", 32'(wc[3] - wc[0]), 3);
`ifdef NAT1_LOADER_CHECKSUM_EN
    check("t2_checksum", 32'(checksum), 32'hAA);
`endif

    // T3: non-SOP beats in ARMED are discarded
    clear_log();
    pulse_start();
    check("t3_done_cleared", 32'(done), 0);
    check("t3_count_cleared", 32'(byte_count), 0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h5A, 1'b1, 1'b1);
    idle(2);
    check("t3_writes", 32'(wa.size()), 1);
    check("t3_addr", 32'(wa[0]), 0);
    check("t3_data", 32'(wd[0]), 32'h5A);
    check("t3_count", 32'(byte_count), 1);
    check("t3_done", 32'(done), 1);
`ifdef NAT1_LOADER_CHECKSUM_EN
    check("t3_checksum", 32'(checksum), 32'h5A);
`endif

    // T4: 1030-beat packet overflows after 1024 writes
    clear_log();
    pulse_start();
    for (int i = 0; i < 1030; i++) begin
      send(8'(i), i == 0, i == 1029);
      if (i == 1022) check("t4_ovf_before", 32'(overflow), 0);
      if (i == 1023) begin
        check("t4_ovf_at_1024", 32'(overflow), 1);
        check("t4_count_at_1024", 32'(byte_count), 1024);
      end
    end
    idle(2);
    check("t4_writes", 32'(wa.size()), 1024);
    bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] != i || wd[i] != (i & 255)) bad++;
    end
    check("t4_write_content", 32'(bad), 0);
    check("t4_done", 32'(done), 1);
    check("t4_ovf", 32'(overflow), 1);
    check("t4_count", 32'(byte_count), 1024);
`ifdef NAT1_LOADER_CHECKSUM_EN
    check("t4_checksum", 32'(checksum), 32'h00);
`endif

    // T5: abort mid-load together with start
    clear_log();
    pulse_start();
    send(8'hA1, 1'b1, 1'b0);
    send(8'hA2, 1'b0, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA3;
    check("t5_ready", 32'(s_ready), 0);
    check("t5_busy", 32'(busy), 0);
    idle(3);
    check("t5_writes", 32'(wa.size()), 2);
    check("t5_count", 32'(byte_count), 2);
    check("t5_done", 32'(done), 0);
    s_valid = 1'b0;
    start   = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("t5_abort_wins_idle", 32'(busy), 0);

    // T6: 16-byte packet with random valid gaps, then RAM readback
    clear_log();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 2));
      send(8'(i * 37 + 5), i == 0, i == 15);
    end
    idle(2);
    check("t6_count", 32'(byte_count), 16);
    check("t6_done", 32'(done), 1);
    check("t6_writes", 32'(wa.size()), 16);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 10'(i);
      exp_b   = 8'(i * 37 + 5);
      @(negedge clk);
      if (rd_q !== exp_b) bad++;
    end
    check("t6_readback", 32'(bad), 0);
`ifdef NAT1_LOADER_CHECKSUM_EN
    check("t6_checksum", 32'(checksum), 32'hA8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
